// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder, LSB first, WIDTH cycles per addition.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= {fa_sum, res[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          // Last bit: publish the completed result directly from the adder.
          if (cnt == CW'(WIDTH - 1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            sum_out <= {fa_sum, res[WIDTH-1:1]};
            cout    <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= carry ^ fa_cout;
`endif
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8); checks ovf when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [W+1:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {ovf, cout, sum}; ovf is zero when the feature is not built
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef SERIAL_ADDER_OVF_EN
    v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
    v = 1'b0;
`endif
    return {v, s};
  endfunction

  function automatic logic [W+1:0] observed();
`ifdef SERIAL_ADDER_OVF_EN
    return {ovf, cout, sum_out};
`else
    return {1'b0, cout, sum_out};
`endif
  endfunction

  task automatic wait_done(output int k, output int bc);
    k  = 0;
    bc = 0;
    while (!done && k < 4 * W) begin
      if (busy) bc++;
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic pop_cmp(input string tag);
    logic [W+1:0] e;
    e = exp_q.pop_front();
    check(tag, observed(), e);
  endtask

  // Caller guarantees IDLE. inject=1 re-pulses start with other operands in ADD cycle 3.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input bit timing, input bit inject, input string tag);
    int k;
    int bc;
    logic [W+1:0] held;
    a_in = a; b_in = b; cin = c; start = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = ~a;
    b_in  = a ^ b;
    cin   = ~c;
    if (inject) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(k, bc);
      k  += 3;
      bc += 3;
    end else begin
      wait_done(k, bc);
    end
    check({tag, "_done"}, done, 1'b1);
    if (!done) begin
      void'(exp_q.pop_front());
    end else begin
      if (timing) begin
        check({tag, "_latency"}, k, W);
        check({tag, "_busycycles"}, bc, W);
      end
      held = exp_q[0];
      pop_cmp({tag, "_result"});
      @(posedge clk); #1;
      if (timing) begin
        check({tag, "_donepulse"}, done, 1'b0);
        check({tag, "_hold"}, observed(), held);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int bc;
    logic [W-1:0] corners [5];
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'hFF;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", observed(), '0);

    do_op(8'h0F, 8'h01, 1'b0, 1, 0, "basic");
    do_op(8'hFF, 8'h01, 1'b0, 1, 0, "wrap");
    do_op(8'h00, 8'h00, 1'b1, 1, 0, "cin_only");
    do_op(8'h7F, 8'h01, 1'b0, 1, 0, "pos_ovf");
    do_op(8'h80, 8'hFF, 1'b0, 1, 0, "neg_ovf");
    do_op(8'h3C, 8'h55, 1'b1, 1, 1, "repulse");

    // Reset during ADD cycle 4: no done, outputs cleared
    do_op(8'hAA, 8'h77, 1'b1, 0, 0, "pre_abort");
    a_in = 8'hC3; b_in = 8'h5A; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_result", observed(), '0);
    wait_done(k, bc);
    check("abort_nodone", done, 1'b0);
    do_op(8'h21, 8'h43, 1'b0, 1, 0, "post_abort");

    // Back-to-back with start held high
    a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h12, 8'h34, 1'b0));
    @(posedge clk); #1;
    wait_done(k, bc);
    check("b2b_first_latency", k, W);
    pop_cmp("b2b_first_result");
    a_in = 8'hA5; b_in = 8'h5A; cin = 1'b1;
    exp_q.push_back(model(8'hA5, 8'h5A, 1'b1));
    @(posedge clk); #1;
    wait_done(k, bc);
    check("b2b_period", k + 1, W + 2);
    start = 1'b0;
    pop_cmp("b2b_second_result");
    @(posedge clk); #1;
    @(posedge clk); #1;

    for (int unsigned i = 0; i < 5; i++)
      for (int unsigned j = 0; j < 5; j++)
        for (int unsigned c = 0; c < 2; c++)
          do_op(corners[i], corners[j], c[0], 0, 0, "corner");

    for (int unsigned n = 0; n < 1500; n++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 0, 0, "random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
